// File: rtl/sfp_link_pkg.sv
// Shared definitions for the SFP link supervisor: state encodings,
// default 60 MHz timing constants and the timer width helper.
package sfp_link_pkg;

  typedef enum logic [1:0] {
    ST_DOWN    = 2'd0,
    ST_ACQUIRE = 2'd1,
    ST_UP      = 2'd2,
    ST_FAULT   = 2'd3
  } link_state_e;

  // 100 us of healthy link and 1 ms of sustained loss at 60 MHz
  localparam int unsigned LOCK_CYC_60M    = 32'd6000;
  localparam int unsigned HOLDOFF_CYC_60M = 32'd60000;

  // Width able to hold the larger of the two terminal counts
  function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b);
    int unsigned m;
    m = (a > b) ? a : b;
    return $clog2(m) + 32'd1;
  endfunction

endpackage

// File: rtl/link_timer.sv
// Shared qualification / holdoff counter. Clear has priority over
// increment, and the count parks at the terminal value so it never wraps.
module link_timer #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         res,
  input  logic         clr,
  input  logic         inc,
  input  logic [W-1:0] term,
  output logic         done
);

  logic [W-1:0] cnt_r;

  assign done = (cnt_r == term);

  // Counter register: synchronous reset, clear, then increment until terminal
  always_ff @(posedge clk) begin
    if (res) begin
      cnt_r <= {W{1'b0}};
    end else if (clr) begin
      cnt_r <= {W{1'b0}};
    end else if (inc && !done) begin
      cnt_r <= cnt_r + {{(W-1){1'b0}}, 1'b1};
    end else begin
      cnt_r <= cnt_r;
    end
  end

endmodule

// File: rtl/sfp_link_supervisor.sv
// SFP link supervisor and output gate. Received channels are forced low
// unless the link has qualified; hard SFP faults latch until cleared.
// Optional feature macro: LINK_ERR_CNT_EN builds the saturating link
// error counter; without it o_err_cnt is tied to zero.
module sfp_link_supervisor
  import sfp_link_pkg::*;
#(
  parameter int unsigned CH          = 4,
  parameter int unsigned LOCK_CYC    = LOCK_CYC_60M,
  parameter int unsigned HOLDOFF_CYC = HOLDOFF_CYC_60M,
  parameter int unsigned ERR_W       = 8
) (
  input  logic             i_clk,
  input  logic             i_res,
  input  logic [CH-1:0]    i_rx_data,
  input  logic             i_my_lock,
  input  logic             i_rx_lock,
  input  logic             i_master,
  input  logic             i_sfp_los,
  input  logic             i_sfp_tx_flt,
  input  logic             i_mod_abs,
  input  logic             i_fault_clr,
  output logic [CH-1:0]    o_data,
  output logic             o_link_up,
  output logic [1:0]       o_state,
  output logic             o_tx_en,
  output logic [ERR_W-1:0] o_err_cnt
);

  localparam int unsigned TW = cnt_width(LOCK_CYC, HOLDOFF_CYC);
  localparam logic [TW-1:0] LOCK_TERM    = TW'(LOCK_CYC - 32'd1);
  localparam logic [TW-1:0] HOLDOFF_TERM = TW'(HOLDOFF_CYC - 32'd1);

  link_state_e   state_r, next_s;
  logic          good_s, hard_s;
  logic          tmr_clr_s, tmr_inc_s, tmr_done_s;
  logic [TW-1:0] tmr_term_s;
  logic [CH-1:0] data_r;
  logic          link_up_r, tx_en_r;

  assign good_s = i_my_lock & ~i_sfp_los & (i_rx_lock | ~i_master);
  assign hard_s = i_sfp_tx_flt | i_mod_abs;

  // One timer serves ACQUIRE qualification and UP holdoff; it restarts on
  // every state change, and a healthy cycle in UP restarts the holdoff.
  assign tmr_term_s = (state_r == ST_ACQUIRE) ? LOCK_TERM : HOLDOFF_TERM;
  assign tmr_clr_s  = (next_s != state_r) | ((state_r == ST_UP) & good_s);
  assign tmr_inc_s  = ~hard_s & (((state_r == ST_ACQUIRE) & good_s) |
                                 ((state_r == ST_UP) & ~good_s));

  link_timer #(.W(TW)) u_timer (
    .clk  (i_clk),
    .res  (i_res),
    .clr  (tmr_clr_s),
    .inc  (tmr_inc_s),
    .term (tmr_term_s),
    .done (tmr_done_s)
  );

  // Next-state logic; hard faults override every other transition
  always_comb begin
    next_s = state_r;
    case (state_r)
      ST_DOWN: begin
        if (hard_s)      next_s = ST_FAULT;
        else if (good_s) next_s = ST_ACQUIRE;
        else             next_s = ST_DOWN;
      end
      ST_ACQUIRE: begin
        if (hard_s)          next_s = ST_FAULT;
        else if (!good_s)    next_s = ST_DOWN;
        else if (tmr_done_s) next_s = ST_UP;
        else                 next_s = ST_ACQUIRE;
      end
      ST_UP: begin
        if (hard_s)                    next_s = ST_FAULT;
        else if (!good_s && tmr_done_s) next_s = ST_DOWN;
        else                           next_s = ST_UP;
      end
      ST_FAULT: begin
        if (i_fault_clr && !hard_s) next_s = ST_DOWN;
        else                        next_s = ST_FAULT;
      end
      default: next_s = ST_DOWN;
    endcase
  end

  // State and output registers; data passes only in a healthy UP cycle
  always_ff @(posedge i_clk) begin
    if (i_res) begin
      state_r   <= ST_DOWN;
      data_r    <= {CH{1'b0}};
      link_up_r <= 1'b0;
      tx_en_r   <= 1'b1;
    end else begin
      state_r   <= next_s;
      data_r    <= ((state_r == ST_UP) && good_s && !hard_s) ? i_rx_data : {CH{1'b0}};
      link_up_r <= (next_s == ST_UP);
      tx_en_r   <= (next_s != ST_FAULT);
    end
  end

  assign o_state   = state_r;
  assign o_data    = data_r;
  assign o_link_up = link_up_r;
  assign o_tx_en   = tx_en_r;

`ifdef LINK_ERR_CNT_EN
  logic             good_prev_r;
  logic             err_evt_s;
  logic [ERR_W-1:0] err_cnt_r;

  // Event: link went bad while UP, or FAULT was just entered (one per cycle)
  assign err_evt_s = ((state_r == ST_UP) & good_prev_r & ~good_s) |
                     ((next_s == ST_FAULT) & (state_r != ST_FAULT));

  // Saturating error counter plus the previous-cycle health flag
  always_ff @(posedge i_clk) begin
    if (i_res) begin
      good_prev_r <= 1'b0;
      err_cnt_r   <= {ERR_W{1'b0}};
    end else begin
      good_prev_r <= good_s;
      if (err_evt_s && (err_cnt_r != {ERR_W{1'b1}})) begin
        err_cnt_r <= err_cnt_r + {{(ERR_W-1){1'b0}}, 1'b1};
      end else begin
        err_cnt_r <= err_cnt_r;
      end
    end
  end

  assign o_err_cnt = err_cnt_r;
`else
  assign o_err_cnt = {ERR_W{1'b0}};
`endif

endmodule

// File: tb/tb_sfp_link_supervisor.sv
// Bench for sfp_link_supervisor: a run-length behavioural model checked
// every cycle, plus hand-computed checkpoints along directed scenarios.
module tb_sfp_link_supervisor;

  localparam int CH   = 4;
  localparam int LOCK = 8;
  localparam int HOLD = 16;
  localparam int EW   = 2;
  localparam int EMAX = 3;
`ifdef LINK_ERR_CNT_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          res, my_lock, rx_lock, master, los, flt, abs_m, clr;
  logic [CH-1:0] rx;
  logic [CH-1:0] o_data;
  logic          o_link_up, o_tx_en;
  logic [1:0]    o_state;
  logic [EW-1:0] o_err_cnt;

  sfp_link_supervisor #(.CH(CH), .LOCK_CYC(LOCK), .HOLDOFF_CYC(HOLD), .ERR_W(EW)) dut (
    .i_clk(clk), .i_res(res), .i_rx_data(rx), .i_my_lock(my_lock),
    .i_rx_lock(rx_lock), .i_master(master), .i_sfp_los(los),
    .i_sfp_tx_flt(flt), .i_mod_abs(abs_m), .i_fault_clr(clr),
    .o_data(o_data), .o_link_up(o_link_up), .o_state(o_state),
    .o_tx_en(o_tx_en), .o_err_cnt(o_err_cnt)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int err_exp(input int n);
    if (!ERR_EN) return 0;
    return (n > EMAX) ? EMAX : n;
  endfunction

  // ---------------- behavioural model ----------------
  // Model names: 0 DOWN, 1 ACQUIRE, 2 UP, 3 FAULT. m_run counts the
  // consecutive qualifying cycles seen so far in the current state.
  int            m_state = 0;
  int            m_run   = 0;
  int            m_err   = 0;
  bit            m_pg    = 1'b0;
  bit            m_valid = 1'b0;
  logic [CH-1:0] m_data  = '0;

  always @(posedge clk) begin
    bit g, h, ev;
    g  = my_lock & ~los & (rx_lock | ~master);
    h  = flt | abs_m;
    ev = 1'b0;
    if (res) begin
      m_state = 0; m_run = 0; m_err = 0; m_pg = 1'b0; m_data = '0; m_valid = 1'b1;
    end else begin
      m_data = (m_state == 2 && g && !h) ? rx : '0;
      if (h) begin
        if (m_state != 3) ev = 1'b1;
        m_state = 3;
      end else begin
        case (m_state)
          0: if (g) begin m_state = 1; m_run = 0; end
          1: begin
            if (!g) m_state = 0;
            else begin
              m_run++;
              if (m_run == LOCK) begin m_state = 2; m_run = 0; end
            end
          end
          2: begin
            if (g) m_run = 0;
            else begin
              if (m_pg) ev = 1'b1;
              m_run++;
              if (m_run == HOLD) m_state = 0;
            end
          end
          default: if (clr) m_state = 0;
        endcase
      end
      if (ev && m_err < EMAX) m_err++;
      m_pg = g;
    end
  end

  // Compare DUT with the model on every falling edge
  always @(negedge clk) begin
    if (m_valid) begin
      check("model_state",   o_state,   m_state);
      check("model_link_up", o_link_up, (m_state == 2));
      check("model_tx_en",   o_tx_en,   (m_state != 3));
      check("model_data",    o_data,    m_data);
      check("model_err_cnt", o_err_cnt, err_exp(m_err));
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    res = 1'b1;
    step();
    step();
    res = 1'b0;
  endtask

  task automatic bring_up();
    my_lock = 1'b1; los = 1'b0; rx = 4'hA;
    repeat (9) step();
    check("bu_state", o_state, 2);
    step();
  endtask

  initial begin
    res = 1'b1; my_lock = 1'b0; rx_lock = 1'b0; master = 1'b1; los = 1'b1;
    flt = 1'b0; abs_m = 1'b0; clr = 1'b0; rx = 4'h0;
    step(); step();
    check("rst_state", o_state, 0);
    check("rst_data", o_data, 0);
    check("rst_link_up", o_link_up, 0);
    check("rst_tx_en", o_tx_en, 1);
    check("rst_err", o_err_cnt, 0);
    res = 1'b0;

    // Acquire
    my_lock = 1'b1; los = 1'b0; rx_lock = 1'b1; rx = 4'hA;
    step();          check("acq_state_1", o_state, 1);
    repeat (7) step(); check("acq_still", o_state, 1);
    step();          check("acq_up", o_state, 2);
    check("acq_link_up", o_link_up, 1);
    check("acq_data_lat", o_data, 0);
    step();          check("acq_data", o_data, 4'hA);
    check("acq_err", o_err_cnt, err_exp(0));

    // Glitch in UP
    los = 1'b1; rx = 4'h5;
    step(); check("gl_data0", o_data, 0); check("gl_state", o_state, 2);
    step(); step();
    los = 1'b0;
    step(); check("gl_resume", o_data, 4'h5); check("gl_state2", o_state, 2);
    check("gl_err", o_err_cnt, err_exp(1));

    // Interrupted acquire
    do_reset();
    my_lock = 1'b1;
    repeat (5) step(); check("ia_acq", o_state, 1);
    my_lock = 1'b0;
    step(); check("ia_down", o_state, 0);
    my_lock = 1'b1;
    step(); check("ia_reacq", o_state, 1);
    repeat (7) step(); check("ia_not_up", o_state, 1);
    step(); check("ia_up", o_state, 2);

    // Sustained loss
    do_reset();
    bring_up();
    my_lock = 1'b0;
    repeat (15) step(); check("sl_hold", o_state, 2); check("sl_data0", o_data, 0);
    step(); check("sl_down", o_state, 0); check("sl_link", o_link_up, 0);
    check("sl_err", o_err_cnt, err_exp(1));
    my_lock = 1'b1;
    step(); check("sl_acq", o_state, 1);
    repeat (7) step(); check("sl_acq2", o_state, 1);
    step(); check("sl_up", o_state, 2);

    // Hard fault
    flt = 1'b1;
    step(); check("hf_state", o_state, 3); check("hf_tx", o_tx_en, 0); check("hf_data", o_data, 0);
    clr = 1'b1;
    step(); check("hf_clr_ignored", o_state, 3);
    clr = 1'b0; flt = 1'b0;
    step(); check("hf_not_remembered", o_state, 3);
    clr = 1'b1;
    step(); check("hf_cleared", o_state, 0); check("hf_tx_back", o_tx_en, 1);
    check("hf_err", o_err_cnt, err_exp(2));
    clr = 1'b0;

    // Slave mode ignores peer lock; master mode needs it
    do_reset();
    master = 1'b0; rx_lock = 1'b0;
    bring_up();
    check("slave_data", o_data, 4'hA);
    master = 1'b1;
    step(); check("master_needs_peer", o_data, 0);
    rx_lock = 1'b1;
    step(); check("master_peer_ok", o_data, 4'hA);

    // Saturation
    do_reset();
    bring_up();
    repeat (5) begin
      los = 1'b1; step();
      los = 1'b0; step();
    end
    check("sat_err", o_err_cnt, err_exp(5));
    check("sat_state", o_state, 2);

    // Reset mid-ACQUIRE
    do_reset();
    my_lock = 1'b1;
    repeat (4) step(); check("rm_acq", o_state, 1);
    res = 1'b1;
    step();
    check("rm_state", o_state, 0);
    check("rm_data", o_data, 0);
    check("rm_link", o_link_up, 0);
    check("rm_tx", o_tx_en, 1);
    check("rm_err", o_err_cnt, 0);
    res = 1'b0;
    step(); step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
